// File: rtl/bcd_timer_chain.sv
// bcd_timer_chain: prescaled up/down BCD digit cascade with per-digit modulus,
// clamped preset, sticky zero flag, lap-hold display and active-low 7-segment drive.
module bcd_timer_chain #(
   parameter int          CLK_HZ     = 50000000,
   parameter int          TICK_HZ    = 1,
   parameter int          NUM_DIGITS = 4,
   parameter logic [31:0] DIGIT_MAX  = 32'h5959_5959
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    RUN,
   input  logic                    DIR,
   input  logic                    LOAD,
   input  logic [4*NUM_DIGITS-1:0] LOAD_VALUE,
   input  logic                    LAP,
   output logic [4*NUM_DIGITS-1:0] COUNT,
   output logic [4*NUM_DIGITS-1:0] DISP,
   output logic [7*NUM_DIGITS-1:0] HEX,
   output logic                    TICK,
   output logic                    WRAP,
   output logic                    DONE
);
   localparam int W   = 4*NUM_DIGITS;
   localparam int DIV = CLK_HZ/TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [PW-1:0] presc;
   logic [W-1:0]  up_nxt, dn_nxt, ld_val;
   logic          all_max, all_zero;
   logic          expire;
   // ripple enables: a digit moves only when every lower digit sits at its limit
   always_comb begin
      logic [3:0] d, m;
      logic       c_up, c_dn;
      d = '0;
      m = '0;
      c_up = 1'b1;
      c_dn = 1'b1;
      up_nxt = COUNT;
      dn_nxt = COUNT;
      ld_val = LOAD_VALUE;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         d = COUNT[4*k +: 4];
         m = DIGIT_MAX[4*k +: 4];
         up_nxt[4*k +: 4] = c_up ? (d == m ? 4'd0 : d + 4'd1) : d;
         dn_nxt[4*k +: 4] = c_dn ? (d == 4'd0 ? m : d - 4'd1) : d;
         ld_val[4*k +: 4] = LOAD_VALUE[4*k +: 4] > m ? m : LOAD_VALUE[4*k +: 4];
         c_up = c_up & (d == m);
         c_dn = c_dn & (d == 4'd0);
      end
      all_max = c_up;
      all_zero = c_dn;
   end
   assign expire = RUN && presc == PW'(DIV-1);
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
         COUNT <= '0;
         DISP  <= '0;
         TICK  <= 1'b0;
         WRAP  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         TICK <= 1'b0;
         WRAP <= 1'b0;
         DISP <= LAP ? DISP : COUNT;
         if (LOAD) begin
            COUNT <= ld_val;
            presc <= '0;
            DONE  <= 1'b0;
         end else if (expire) begin
            presc <= '0;
            TICK  <= 1'b1;
            WRAP  <= !DIR && all_max;
            COUNT <= DIR ? (all_zero ? COUNT : dn_nxt) : up_nxt;
            DONE  <= DONE | (DIR & (all_zero | dn_nxt == '0));
         end else if (RUN) begin
            presc <= presc + 1'b1;
         end
      end
   end
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hex
      assign HEX[7*i +: 7] = GLYPH[DISP[4*i +: 4]];
   end
endmodule

// File: doc/bcd_timer_chain.md
Name: bcd_timer_chain

Overview:
- Parametrised BCD time-counter chain, the successor to the fixed 4-digit mm:ss clock.
- Contains a tick prescaler, a configurable-length cascade of BCD digits with per-digit modulus, up/down counting, preset load, a zero-terminal alarm and a lap-hold display register.
- Drives per-digit active-low 7-segment codes directly.
- Sits between the board clock and the HEX displays; control inputs come from debounced KEY logic.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, count rate. Prescaler divisor DIV = CLK_HZ/TICK_HZ; DIV >= 2 required.
- NUM_DIGITS, 4, number of BCD digits in the chain (1..8).
- DIGIT_MAX, 32'h5959_5959, packed 4 bits per digit, digit 0 in [3:0]. Maximum value of each digit; each field must be 1..9.

Ports:
- CLK, in, 1, system clock, rising edge.
- RST_N, in, 1, asynchronous active-low reset.
- RUN, in, 1, 1 = prescaler advances and counting is enabled.
- DIR, in, 1, 0 = count up, 1 = count down.
- LOAD, in, 1, synchronous preset strobe.
- LOAD_VALUE, in, 4*NUM_DIGITS, preset BCD digits.
- LAP, in, 1, 1 = freeze display.
- COUNT, out, 4*NUM_DIGITS, live BCD count.
- DISP, out, 4*NUM_DIGITS, displayed BCD value (live or lap-held).
- HEX, out, 7*NUM_DIGITS, active-low 7-segment code of DISP, digit i in [7i+6:7i]. Encoding: 0=1000000, 1=1111001 … 9=0010000, A–F hex glyphs.
- TICK, out, 1, one-cycle pulse when the prescaler expires.
- WRAP, out, 1, one-cycle pulse on up-count rollover from all-max to all-zero.
- DONE, out, 1, sticky down-count terminal flag.

Behaviour:
- Reset (RST_N=0, async): prescaler=0, COUNT=0, DISP=0, TICK=0, WRAP=0, DONE=0, HEX = glyph "0" on all digits.

Prescaler:
- Counts 0..DIV-1 only while RUN=1; holds its value while RUN=0.
- At DIV-1 with RUN=1: returns to 0 and TICK=1 for the next cycle.
- COUNT updates on the same edge TICK is registered, so a change in COUNT and the TICK pulse are visible together.
- First tick after reset with RUN held high: TICK high in cycle DIV.

Up count (DIR=0, tick):
- Digit i increments iff all digits j<i equal DIGIT_MAX[j].
- A digit at its max wraps to 0.
- All digits at max -> all 0, and WRAP=1 for one cycle.

Down count (DIR=1, tick):
- Digit i decrements iff all digits j<i equal 0.
- A digit at 0 borrows, reloading to DIGIT_MAX[i].
- Tick that produces all-zero sets DONE.
- Tick while already all-zero: COUNT holds (no wrap), DONE set/kept.
- WRAP never pulses in down mode.

LOAD:
- Has priority over a tick in the same cycle.
- COUNT <= LOAD_VALUE, with each digit clamped to min(value, DIGIT_MAX[i]).
- Clears prescaler to 0 and clears DONE.
- No TICK/WRAP that cycle.
- LOAD with RUN=0 is legal.

DONE:
- Cleared only by reset or LOAD.
- DIR change does not clear it.
- Counting continues normally if DIR switches to up.

DIR changes:
- Take effect on the next tick; no glitch in COUNT.

Display:
- LAP=0: DISP <= COUNT each cycle (one-cycle lag).
- LAP=1: DISP holds its value, including through LOAD/ticks.
- On LAP release, DISP resumes tracking on the next edge.
- HEX is combinational from DISP.

Invariants:
- Out-of-range digits are never produced.
- Widths are exact; no arithmetic beyond 4 bits per digit.

Test Plan:
- Reset: CLK_HZ=10, TICK_HZ=1, defaults. Assert RST_N=0 mid-count -> COUNT=0000, DONE=0, HEX all 7'b1000000 immediately, without a clock edge.
- Up rollover: LOAD_VALUE=16'h5958, RUN=1, DIR=0. After 1 tick -> 5959; after next tick -> 0000 with WRAP=1 for one cycle. Ticks are spaced exactly 10 cycles apart.
- Carry chain: load 0959, one tick -> 1000. Load 16'h9F9F -> clamps to 5959.
- Down terminal: load 0002, DIR=1. Ticks -> 0001, then 0000 with DONE=1; a further tick holds 0000 with DONE=1. Load 0100, DIR=1, tick -> 0059 (borrow reloads max); DONE cleared by the load.
- Lap hold: counting up from 0000, raise LAP at 0003. DISP stays 0003 while COUNT reaches 0007. Release LAP -> DISP=0007 one cycle later.
- Priority and RUN: LOAD coincident with a tick -> COUNT=LOAD_VALUE, no TICK side effects, prescaler restarts at 0. RUN=0 for 25 cycles -> COUNT and prescaler frozen; resume -> next tick comes after the remaining prescaler cycles.
